// File: rtl/uart_rxbuf_reader.sv
// uart_rxbuf_reader: drain controller for the UART receive buffer.
// Follows the buffer tail through the per-byte received pulse, keeps its own
// head pointer and fill level, fetches bytes through the buffer address port
// and presents them on a valid/ready stream. Detects overrun and supports flush.
module uart_rxbuf_reader #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DW     = 8,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic [AW-1:0] buf_tail,
  input  logic          buf_rcvd,
  output logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          overflow
);

  // Fetch counter must at least hold RD_LAT; keep one bit for RD_LAT = 0.
  localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ZERO = {(AW + 1){1'b0}};
  localparam logic [CW-1:0] CNT_LAST   = CW'(RD_LAT);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

  logic [1:0]    state_r,    state_nx_s;
  logic [CW-1:0] cnt_r,      cnt_nx_s;
  logic [AW-1:0] head_r,     head_nx_s;
  logic [AW:0]   level_r,    level_nx_s;
  logic [DW-1:0] m_data_r,   m_data_nx_s;
  logic          m_valid_r,  m_valid_nx_s;
  logic          overflow_r, overflow_nx_s;
  logic          fetch_last_s;
  logic          cap_s;
  logic          overrun_s;

  // Capture and overrun qualifiers; flush suppresses both.
  always_comb begin
    fetch_last_s = (cnt_r == CNT_LAST);
    cap_s        = 1'b0;
    overrun_s    = 1'b0;
    if ((state_r == ST_FETCH) && fetch_last_s && !flush) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
    // A write into a full buffer that is not offset by a capture drops the oldest byte.
    if (!flush && (level_r == LEVEL_FULL) && buf_rcvd && !cap_s) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = 1'b0;
    end
  end

  // FSM and output-stream next state.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    m_data_nx_s  = m_data_r;
    m_valid_nx_s = m_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (en && (level_r != LEVEL_ZERO) && !m_valid_r && !flush) begin
          state_nx_s = ST_FETCH;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else if (cap_s) begin
          state_nx_s   = ST_HOLD;
          cnt_nx_s     = CNT_ZERO;
          m_data_nx_s  = buf_data;
          m_valid_nx_s = 1'b1;
        end else if (overrun_s) begin
          // The slot under fetch was overwritten: restart from the new head.
          cnt_nx_s = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CW'(1'b1);
        end
      end
      ST_HOLD: begin
        // The held byte is already dequeued, so flush does not drop it.
        if (m_valid_r && m_ready) begin
          state_nx_s   = ST_IDLE;
          m_valid_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        cnt_nx_s     = CNT_ZERO;
        m_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Head pointer, fill level and sticky overflow next state.
  always_comb begin
    head_nx_s     = head_r;
    level_nx_s    = level_r;
    overflow_nx_s = overflow_r;
    if (flush) begin
      head_nx_s  = buf_tail;
      level_nx_s = LEVEL_ZERO;
    end else if (overrun_s) begin
      head_nx_s  = head_r + AW'(1'b1);
      level_nx_s = LEVEL_FULL;
    end else begin
      head_nx_s  = cap_s ? (head_r + AW'(1'b1)) : head_r;
      level_nx_s = level_r + (AW + 1)'(buf_rcvd) - (AW + 1)'(cap_s);
    end
    // A new overrun wins over a coincident clear.
    if (overrun_s) begin
      overflow_nx_s = 1'b1;
    end else if (clr_ovf) begin
      overflow_nx_s = 1'b0;
    end else begin
      overflow_nx_s = overflow_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      head_r     <= {AW{1'b0}};
      level_r    <= LEVEL_ZERO;
      m_data_r   <= {DW{1'b0}};
      m_valid_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      head_r     <= head_nx_s;
      level_r    <= level_nx_s;
      m_data_r   <= m_data_nx_s;
      m_valid_r  <= m_valid_nx_s;
      overflow_r <= overflow_nx_s;
    end
  end

  assign buf_addr = head_r;
  assign m_data   = m_data_r;
  assign m_valid  = m_valid_r;
  assign level    = level_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_rxbuf_reader.sv
// Directed bench for uart_rxbuf_reader: one instance with a combinational
// buffer read (RD_LAT=0) and one with a two-cycle read pipeline (RD_LAT=2),
// both driven from the same receive-buffer model.
module tb_uart_rxbuf_reader;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en, flush, clr_ovf, buf_rcvd, m_ready;
  logic [AW-1:0] buf_tail;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] buf_addr0, buf_addr2;
  logic [DW-1:0] buf_data0, buf_data2, d1_q;
  logic [DW-1:0] m_data0, m_data2;
  logic          m_valid0, m_valid2;
  logic [AW:0]   level0, level2;
  logic          overflow0, overflow2;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] wptr;
  logic [DW-1:0] exp_q[$];

  // Buffer model: combinational read, and a read with two cycles of latency.
  assign buf_data0 = mem[buf_addr0];
  always @(posedge clk) begin
    d1_q      <= mem[buf_addr2];
    buf_data2 <= d1_q;
  end

  uart_rxbuf_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .clr_ovf(clr_ovf),
    .buf_tail(buf_tail), .buf_rcvd(buf_rcvd), .buf_addr(buf_addr0),
    .buf_data(buf_data0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready), .level(level0), .overflow(overflow0)
  );

  uart_rxbuf_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .clr_ovf(clr_ovf),
    .buf_tail(buf_tail), .buf_rcvd(buf_rcvd), .buf_addr(buf_addr2),
    .buf_data(buf_data2), .m_data(m_data2), .m_valid(m_valid2),
    .m_ready(m_ready), .level(level2), .overflow(overflow2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    buf_rcvd = 1'b0; m_ready = 1'b0; wptr = 3'd0; buf_tail = 3'd0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Writes one byte at the tail; tail advances in the same cycle as the pulse.
  task automatic write_byte(input logic [7:0] d);
    mem[wptr] = d;
    wptr      = wptr + 3'd1;
    buf_tail  = wptr;
    buf_rcvd  = 1'b1;
    @(negedge clk);
    buf_rcvd  = 1'b0;
  endtask

  // Collects n accepted bytes from one instance and checks order and spacing.
  task automatic drain(input bit sel, input int n);
    int got;
    int last_cyc;
    int spacing;
    logic v;
    logic [7:0] d;
    logic [7:0] e;
    got = 0;
    last_cyc = 0;
    spacing = sel ? 5 : 3;
    for (int cyc = 0; (cyc < 40 * n) && (got < n); cyc++) begin
      v = sel ? m_valid2 : m_valid0;
      d = sel ? m_data2 : m_data0;
      if (v && m_ready) begin
        e = exp_q.pop_front();
        check("drain_data", {24'd0, d}, {24'd0, e});
        if (got > 0) check("drain_spacing", cyc - last_cyc, spacing);
        last_cyc = cyc;
        got++;
      end
      @(negedge clk);
    end
    check("drain_count", got, n);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

    // Reset values
    do_reset();
    check("rst_addr", {29'd0, buf_addr0}, 32'd0);
    check("rst_level", {28'd0, level0}, 32'd0);
    check("rst_valid", {31'd0, m_valid0}, 32'd0);
    check("rst_data", {24'd0, m_data0}, 32'd0);
    check("rst_ovf", {31'd0, overflow0}, 32'd0);
    check("rst_ovf2", {31'd0, overflow2}, 32'd0);

    // Three bytes, streamed in order one per 3 cycles
    m_ready = 1'b1;
    write_byte(8'h41); write_byte(8'h42); write_byte(8'h43);
    check("t1_level3", {28'd0, level0}, 32'd3);
    check("t1_idle_valid", {31'd0, m_valid0}, 32'd0);
    en = 1'b1;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    drain(1'b0, 3);
    check("t1_level0", {28'd0, level0}, 32'd0);
    check("t1_addr3", {29'd0, buf_addr0}, 32'd3);

    // Back-pressure: held byte stays stable while more bytes arrive
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    write_byte(8'h41);
    repeat (3) @(negedge clk);
    write_byte(8'h42); write_byte(8'h43);
    check("t2_valid", {31'd0, m_valid0}, 32'd1);
    check("t2_data", {24'd0, m_data0}, 32'h41);
    check("t2_level", {28'd0, level0}, 32'd2);
    m_ready = 1'b1;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    drain(1'b0, 3);
    check("t2_level0", {28'd0, level0}, 32'd0);

    // Overrun with en=0: ninth byte drops slot 0's original byte
    do_reset();
    for (int i = 0; i < 8; i++) write_byte(8'h50 + 8'(i));
    check("t3_full", {28'd0, level0}, 32'd8);
    check("t3_no_ovf", {31'd0, overflow0}, 32'd0);
    write_byte(8'h58);
    check("t3_level", {28'd0, level0}, 32'd8);
    check("t3_ovf", {31'd0, overflow0}, 32'd1);
    check("t3_head", {29'd0, buf_addr0}, 32'd1);
    en = 1'b1; m_ready = 1'b1;
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h50 + 8'(i));
    exp_q.push_back(8'h58);
    drain(1'b0, 8);
    check("t3_level0", {28'd0, level0}, 32'd0);
    check("t3_ovf_sticky", {31'd0, overflow0}, 32'd1);
    check("t3_head_end", {29'd0, buf_addr0}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", {31'd0, overflow0}, 32'd0);

    // Pointer wrap: head moved to 6 by a flush, then 8 bytes
    do_reset();
    wptr = 3'd6; buf_tail = 3'd6; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_head6", {29'd0, buf_addr0}, 32'd6);
    for (int i = 0; i < 8; i++) write_byte(8'h60 + 8'(i));
    check("t4_full", {28'd0, level0}, 32'd8);
    check("t4_no_ovf", {31'd0, overflow0}, 32'd0);
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h60 + 8'(i));
    drain(1'b0, 8);
    check("t4_level0", {28'd0, level0}, 32'd0);
    check("t4_head_end", {29'd0, buf_addr0}, 32'd6);

    // Flush during FETCH, then flush with a coincident write
    do_reset();
    m_ready = 1'b1;
    write_byte(8'h91); write_byte(8'h92); write_byte(8'h93); write_byte(8'h94);
    check("t5_level4", {28'd0, level0}, 32'd4);
    en = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_valid", {31'd0, m_valid0}, 32'd0);
    check("t5_level", {28'd0, level0}, 32'd0);
    check("t5_addr", {29'd0, buf_addr0}, 32'd4);
    flush = 1'b1;
    write_byte(8'h95);
    flush = 1'b0;
    check("t5_rcvd_level", {28'd0, level0}, 32'd0);
    check("t5_rcvd_addr", {29'd0, buf_addr0}, 32'd5);
    repeat (4) @(negedge clk);
    check("t5_still_idle", {31'd0, m_valid0}, 32'd0);

    // Two-cycle read latency: bytes every 5 cycles, correct data
    do_reset();
    m_ready = 1'b1;
    write_byte(8'h71); write_byte(8'h72); write_byte(8'h73);
    en = 1'b1;
    exp_q.push_back(8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
    drain(1'b1, 3);
    check("t6_level0", {28'd0, level2}, 32'd0);
    check("t6_addr3", {29'd0, buf_addr2}, 32'd3);

    // Asynchronous reset while a byte is held
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    write_byte(8'h81); write_byte(8'h82);
    for (int i = 0; (i < 20) && !m_valid2; i++) @(negedge clk);
    check("t6_hold_valid", {31'd0, m_valid2}, 32'd1);
    check("t6_hold_data", {24'd0, m_data2}, 32'h81);
    check("t6_hold_level", {28'd0, level2}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_valid", {31'd0, m_valid2}, 32'd0);
    check("t6_arst_level", {28'd0, level2}, 32'd0);
    check("t6_arst_addr", {29'd0, buf_addr2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rxbuf_reader.md
Name: uart_rxbuf_reader

Overview:
- Drain controller for the 8-entry UART receive buffer.
- Tracks the buffer's tail via the per-byte received pulse and keeps its own head pointer and fill level.
- Sequences random-access reads through the buffer's address port and presents each byte on a valid/ready stream to downstream logic (command parser, TX loopback).
- Detects and flags overrun; supports flush.

Parameters:
- DEPTH, 8, number of buffer entries; power of two.
- AW, 3, address width; log2(DEPTH).
- DW, 8, data width.
- RD_LAT, 0, cycles from buf_addr change to valid buf_data; 0 means a combinational read.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  permit new fetches
- flush  in  1  one-cycle pulse; discard all unread entries
- clr_ovf  in  1  one-cycle pulse; clear overflow
- buf_tail  in  AW  buffer tail_addr (next slot to be written)
- buf_rcvd  in  1  buffer data_rcvd pulse; one per byte written
- buf_addr  out  AW  read address to buffer
- buf_data  in  DW  read data from buffer
- m_data  out  DW  output byte
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- level  out  AW+1  unread entries, 0..DEPTH
- overflow  out  1  sticky overrun flag

Behaviour:
- Reset (async, rst=1): state IDLE, head=0, buf_addr=0, level=0, m_data=0, m_valid=0, overflow=0, fetch counter=0.
- Interface contract: in the cycle buf_rcvd=1, buf_tail already shows the advanced pointer.
- buf_addr always equals head; it is registered.
- level update each cycle: level + buf_rcvd - cap, where cap=1 on a capture cycle.
  - Exception (overrun): level==DEPTH, buf_rcvd=1, cap=0. Then level stays DEPTH, head<=head+1 (oldest byte lost) and overflow<=1.
  - level==DEPTH with buf_rcvd=1 and cap=1: level stays DEPTH, no overflow. The captured byte is the pre-write contents.
- overflow is sticky. It clears only on clr_ovf or rst. If clr_ovf and a new overrun occur in the same cycle, the set wins.
- FSM states:
  - IDLE: if en=1, level!=0 and m_valid=0, go to FETCH with fetch counter=0. Otherwise stay.
  - FETCH: lasts RD_LAT+1 cycles. On the last cycle, cap=1: m_data<=buf_data, m_valid<=1, head<=head+1 (wraps DEPTH-1 to 0), go to HOLD.
  - HOLD: m_valid and m_data stay stable while m_ready=0. On m_valid & m_ready, m_valid<=0 and go to IDLE.
- Throughput: one byte per RD_LAT+3 cycles with m_ready held high.
- Pointer wrap: head and buf_addr are modulo DEPTH. level must never exceed DEPTH or underflow below 0.
- en=0:
  - no new FETCH starts;
  - an in-progress FETCH completes;
  - HOLD proceeds normally;
  - level and overflow tracking continue.
- flush (priority over all other updates except rst):
  - head<=buf_tail, level<=0, any coincident buf_rcvd byte is discarded.
  - FETCH aborts to IDLE with no capture.
  - In HOLD, the held byte stays valid until accepted, since it is already dequeued.
  - overflow is unaffected.
- rst mid-operation: immediate return to reset values. A byte in HOLD is lost.
- An overrun during FETCH targets the slot being fetched only when cap=0. In that case head advances and the fetch restarts from the new head: counter resets, remaining in FETCH.

Test Plan:
- Reset then 3 buf_rcvd pulses, bytes 0x41,0x42,0x43 in slots 0..2, m_ready=1, RD_LAT=0 -> m_data 0x41,0x42,0x43 in order, one per 3 cycles; level 3→0; buf_addr ends 3.
- m_ready=0 while holding 0x41, then 2 more bytes arrive -> m_valid stays 1, m_data=0x41 stable, level=2; release m_ready -> 0x42, 0x43 follow.
- en=0, 9 bytes written to slots 0..7,0 -> level=8, overflow=1 on 9th, head=1; en=1 -> first byte delivered is from slot 1, 8 bytes total; clr_ovf -> overflow=0.
- 8 bytes with head at 6 -> reads slots 6,7,0,1,...,5 in order (wrap), level returns to 0.
- flush in FETCH with level=4, buf_tail=4 -> no capture, level=0, buf_addr=4, m_valid stays 0; buf_rcvd coincident with flush -> level remains 0.
- RD_LAT=2: buf_data changes 2 cycles after buf_addr -> capture occurs on the 3rd FETCH cycle with correct byte; rst asserted during HOLD -> m_valid=0 and level=0 asynchronously.
